// File: rtl/debounce_pkg.sv
// debounce_pkg: shared constants for the four-channel switch debouncer.
`default_nettype none

package debounce_pkg;

  localparam int NUM_CH         = 4;
  localparam int CNT_W_DEF      = 16;
  localparam int STABLE_CNT_DEF = 50000;
  // Short interval so simulations reach a level change in a handful of cycles.
  localparam int STABLE_CNT_SIM = 4;

endpackage

`default_nettype wire

// File: rtl/debounce_ch.sv
// ----------------------------------------------------------------------------
// debounce_ch: one channel -- 2-flop synchroniser, stability counter, level
// register, optional edge pulses (SWITCH_DEBOUNCE_EDGE_EN).
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module debounce_ch #(
  parameter int CNT_W      = 16,
  parameter int STABLE_CNT = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_in,
  output logic sw_out,
  output logic sw_rise,
  output logic sw_fall
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CNT - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  // A new level is taken only after STABLE_CNT consecutive mismatched cycles.
  assign accept = (s2 != sw_out) && (cnt == CNT_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      cnt    <= '0;
      sw_out <= 1'b0;
    end else begin
      s1 <= sw_in;
      s2 <= s1;
      if (s2 == sw_out) begin
        cnt <= '0;
      end else if (accept) begin
        sw_out <= s2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

`ifdef SWITCH_DEBOUNCE_EDGE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_rise <= 1'b0;
      sw_fall <= 1'b0;
    end else begin
      sw_rise <= accept &&  s2;
      sw_fall <= accept && !s2;
    end
  end
`else
  assign sw_rise = 1'b0;
  assign sw_fall = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/switch_debounce4.sv
// ----------------------------------------------------------------------------
// switch_debounce4: four independent debounced switch channels feeding the
// AND-OR gate inputs. Edge pulses enabled by SWITCH_DEBOUNCE_EDGE_EN.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module switch_debounce4
  import debounce_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int STABLE_CNT = STABLE_CNT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] sw_in,
  output logic [NUM_CH-1:0] sw_out,
  output logic [NUM_CH-1:0] sw_rise,
  output logic [NUM_CH-1:0] sw_fall
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    debounce_ch #(
      .CNT_W      (CNT_W),
      .STABLE_CNT (STABLE_CNT)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .sw_in   (sw_in[i]),
      .sw_out  (sw_out[i]),
      .sw_rise (sw_rise[i]),
      .sw_fall (sw_fall[i])
    );
  end

endmodule

`default_nettype wire

// File: doc/switch_debounce4.md
# switch_debounce4

Four-channel input conditioner placed directly upstream of the AND-OR gate logic. It takes four raw board switches or buttons, synchronises each one to `clk`, and debounces it with a stability counter. The clean levels drive the gate inputs one-to-one: `sw_out[0]`..`sw_out[3]` → `in1`..`in4`. Optional one-cycle edge pulses are provided for event-driven consumers.

## Interface
- `CNT_W`, default 16: counter width in bits. Must satisfy `STABLE_CNT <= 2**CNT_W - 1`.
- `STABLE_CNT`, default 50000: consecutive stable cycles needed to accept a new level (1 ms at 50 MHz). Must be ≥ 1.
- `clk`, input, 1: single system clock, rising-edge.
- `rst`, input, 1: reset, asynchronous and active-high.
- `sw_in`, input, 4: raw, asynchronous switch levels.
- `sw_out`, output, 4: debounced levels, registered.
- `sw_rise`, output, 4: one-cycle pulse per channel when `sw_out` goes 0→1.
- `sw_fall`, output, 4: one-cycle pulse per channel when `sw_out` goes 1→0.

## Operation
- Channels are fully independent and identical.
- Synchroniser: two flops per channel, `s1` ← `sw_in` and `s2` ← `s1`. Both reset to 0.
- Each channel holds state `{cnt[CNT_W-1:0], sw_out}` and runs the following rules every rising edge:
  - `s2 == sw_out`: `cnt` ← 0. This is the idle state.
  - `s2 != sw_out` and `cnt != STABLE_CNT-1`: `cnt` ← `cnt + 1`. This is the counting state.
  - `s2 != sw_out` and `cnt == STABLE_CNT-1`: `sw_out` ← `s2`, `cnt` ← 0. Assert `sw_rise` or `sw_fall` (matching the new level) for exactly this one cycle.
- Bounce: any single cycle with `s2 == sw_out` clears `cnt`. A run of mismatched cycles shorter than `STABLE_CNT` never changes `sw_out`.
- `cnt` never exceeds `STABLE_CNT-1`, so no wrap-around is possible.
- Reset value of every output is 0. All internal state (`s1`, `s2`, `cnt`) is also 0.
- Reset asserted mid-count clears everything immediately. No pulse is produced on reset entry or release.
- If `sw_in` is held high through reset release, it is treated as a normal 0→1 change: full interval, then a `sw_rise` pulse.
- Simultaneous changes on several channels resolve independently. They update on the same edge if their stable intervals coincide.
- `sw_rise` and `sw_fall` are never both high on one channel.

## Timing
- Let edge k be the rising edge that first samples a new `sw_in` level into `s1`.
- `sw_out` changes at edge k+1+`STABLE_CNT`, provided the level holds, i.e. a latency of `STABLE_CNT`+1 edges.
- Edge pulses are registered: they go high on the same edge as the `sw_out` change and drop on the next edge.
- `sw_in` has no setup relationship to `clk`; the synchroniser absorbs metastability.

## Configuration
- Macro: `SWITCH_DEBOUNCE_EDGE_EN`.
- Defined: `sw_rise` and `sw_fall` are generated as described above.
- Undefined: the ports remain present but are tied to 4'b0000, and no edge logic or registers are synthesised. `sw_out` behaviour is identical in both cases.

## Structure
- Package `debounce_pkg` holds:
  - `NUM_CH` = 4
  - default `CNT_W` and `STABLE_CNT`
  - a simulation-friendly `STABLE_CNT_SIM` = 4
- Sub-module `debounce_ch` implements one channel: synchroniser, counter, level register and edge pulses. `switch_debounce4` instantiates it `NUM_CH` times with a generate loop.

## Test plan
All scenarios use `STABLE_CNT` = 4.
1. Reset with `rst` = 1 and `sw_in` = 4'hF → `sw_out`, `sw_rise` and `sw_fall` all 0. After release, `sw_out` = 4'hF exactly 5 edges after the first sampling edge, with one `sw_rise` = 4'hF pulse.
2. Clean edge: `sw_in[0]` 0→1 sampled at edge k → `sw_out[0]` = 1 at edge k+5. `sw_rise[0]` is high for exactly one cycle and `sw_fall[0]` stays 0.
3. Bounce: `sw_in[1]` high for 3 cycles, low for 1, then steady high → `sw_out[1]` rises 5 edges after the final rising sample. Exactly one `sw_rise[1]` pulse occurs.
4. Glitch: `sw_in[2]` high for 3 cycles, then low → `sw_out[2]` stays 0 and no pulse occurs.
5. Simultaneous: `sw_in` 4'b0000→4'b1010, then later 4'b1010→4'b0101 → bits 1 and 3 rise together. Then on one edge, bits 1 and 3 fall while bits 0 and 2 rise, with `sw_fall` = 4'b1010 and `sw_rise` = 4'b0101 for one cycle.
6. Reset mid-count: assert `rst` when `cnt` = 2 → outputs drop to 0 immediately. After release, the full 5-edge interval is required again and no spurious pulse appears.
